// File: rtl/periph_bus_pkg.sv
// ============================================================================
// periph_bus_pkg : shared types and constants for the peripheral bus bridge
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Peripheral window indices within the bridge region
  localparam int unsigned C_GPIO_IDX  = 0;
  localparam int unsigned C_LED_IDX   = 1;
  localparam int unsigned C_UART_IDX  = 2;
  localparam int unsigned C_TIMER_IDX = 3;

  localparam logic [31:0] C_DEFAULT_BASE_ADDR   = 32'h8000_0000;
  localparam int unsigned C_DEFAULT_SLAVE_SHIFT = 8;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/periph_bus_bridge_if.sv
// ============================================================================
// periph_bus_bridge_if : CPU-side and peripheral-side signals of the bridge
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface periph_bus_bridge_if #(
  parameter int unsigned NUM_SLAVES = 4
);
  logic                       read_request_i;
  logic                       write_request_i;
  logic [31:0]                address_i;
  logic [31:0]                write_data_i;
  logic [31:0]                read_data_o;
  logic                       response_o;
  logic                       error_o;
  logic [NUM_SLAVES-1:0]      slv_read_request_o;
  logic [NUM_SLAVES-1:0]      slv_write_request_o;
  logic [31:0]                slv_address_o;
  logic [31:0]                slv_write_data_o;
  logic [NUM_SLAVES*32-1:0]   slv_read_data_i;
  logic [NUM_SLAVES-1:0]      slv_response_i;

  // Bridge view
  modport master (
    input  read_request_i, write_request_i, address_i, write_data_i,
    input  slv_read_data_i, slv_response_i,
    output read_data_o, response_o, error_o,
    output slv_read_request_o, slv_write_request_o, slv_address_o, slv_write_data_o
  );

  // Environment view (CPU plus peripherals)
  modport slave (
    output read_request_i, write_request_i, address_i, write_data_i,
    output slv_read_data_i, slv_response_i,
    input  read_data_o, response_o, error_o,
    input  slv_read_request_o, slv_write_request_o, slv_address_o, slv_write_data_o
  );
endinterface

`default_nettype wire

// File: rtl/periph_addr_decode.sv
// ============================================================================
// periph_addr_decode : combinational region hit / peripheral index decode
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module periph_addr_decode
  import periph_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter logic [31:0] BASE_ADDR   = C_DEFAULT_BASE_ADDR,
  parameter int unsigned SLAVE_SHIFT = C_DEFAULT_SLAVE_SHIFT,
  parameter int unsigned SEL_W       = sel_width(NUM_SLAVES)
) (
  input  logic [31:SLAVE_SHIFT] addr_hi,
  output logic                  valid,
  output logic [SEL_W-1:0]      idx
);

  logic w_hit;

  assign w_hit = (addr_hi[31:SLAVE_SHIFT+SEL_W] == BASE_ADDR[31:SLAVE_SHIFT+SEL_W]);
  assign idx   = addr_hi[SLAVE_SHIFT+:SEL_W];
  assign valid = w_hit && (32'(idx) < NUM_SLAVES);

endmodule

`default_nettype wire

// File: rtl/periph_bus_bridge.sv
// ============================================================================
// periph_bus_bridge : registers CPU accesses and forwards them one-hot to the
// peripheral ports. Optional ACCESS timeout enabled by BRIDGE_TIMEOUT_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module periph_bus_bridge
  import periph_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = C_DEFAULT_BASE_ADDR,
  parameter int unsigned SLAVE_SHIFT    = C_DEFAULT_SLAVE_SHIFT,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  periph_bus_bridge_if.master bus
);

  localparam int unsigned SEL_W         = sel_width(NUM_SLAVES);
  localparam logic [31:0] C_OFFSET_MASK = (32'd1 << SLAVE_SHIFT) - 32'd1;

  state_t r_state, w_next;

  logic [31:0]           r_addr, r_wdata, r_rdata;
  logic                  r_write, r_error;
  logic [SEL_W-1:0]      r_idx;
  logic                  w_valid, w_req_any, w_req_ok, w_slv_resp, w_timeout;
  logic [SEL_W-1:0]      w_idx;
  logic [NUM_SLAVES-1:0] w_onehot;

  periph_addr_decode #(
    .NUM_SLAVES  (NUM_SLAVES),
    .BASE_ADDR   (BASE_ADDR),
    .SLAVE_SHIFT (SLAVE_SHIFT),
    .SEL_W       (SEL_W)
  ) u_decode (
    .addr_hi (bus.address_i[31:SLAVE_SHIFT]),
    .valid   (w_valid),
    .idx     (w_idx)
  );

  assign w_req_any  = bus.read_request_i | bus.write_request_i;
  assign w_req_ok   = w_valid && (bus.read_request_i ^ bus.write_request_i);
  assign w_slv_resp = bus.slv_response_i[r_idx];

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_count;

  // Zero on the first ACCESS cycle, so ACCESS lasts exactly TIMEOUT_CYCLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_count <= '0;
    else if (r_state == ACCESS) r_count <= r_count + 1'b1;
    else                       r_count <= '0;
  end

  assign w_timeout = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next                  = r_state;
    w_onehot                = '0;
    w_onehot[r_idx]         = 1'b1;
    bus.slv_read_request_o  = '0;
    bus.slv_write_request_o = '0;
    bus.response_o          = 1'b0;
    bus.error_o             = 1'b0;
    bus.read_data_o         = '0;
    case (r_state)
      IDLE: begin
        if (w_req_any) w_next = w_req_ok ? ACCESS : DONE;
      end
      ACCESS: begin
        if (r_write) bus.slv_write_request_o = w_onehot;
        else         bus.slv_read_request_o  = w_onehot;
        if (w_slv_resp || w_timeout) w_next = DONE;
      end
      DONE: begin
        bus.response_o  = 1'b1;
        bus.error_o     = r_error;
        bus.read_data_o = r_error ? '0 : r_rdata;
        w_next          = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // All access fields are frozen in IDLE; later CPU changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_write <= 1'b0;
      r_error <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_any) begin
            r_addr  <= bus.address_i & C_OFFSET_MASK;
            r_wdata <= bus.write_data_i;
            r_write <= bus.write_request_i;
            r_idx   <= w_idx;
            r_error <= !w_req_ok;
            r_rdata <= '0;
          end
        end
        ACCESS: begin
          if (w_slv_resp) begin
            r_rdata <= r_write ? '0 : bus.slv_read_data_i[r_idx*32 +: 32];
            r_error <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.slv_address_o    = r_addr;
  assign bus.slv_write_data_o = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_periph_bus_bridge.sv
// ============================================================================
// tb_periph_bus_bridge : table-driven bench for periph_bus_bridge
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_periph_bus_bridge;
  import periph_bus_pkg::*;

  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  periph_bus_bridge_if #(.NUM_SLAVES(NS)) bus ();

  periph_bus_bridge #(
    .NUM_SLAVES     (NS),
    .BASE_ADDR      (32'h8000_0000),
    .SLAVE_SHIFT    (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Peripheral model: responds once a request has been held for slv_delay cycles;
  // with stray set, the non-addressed slaves also pulse response meanwhile.
  int unsigned   acc_cnt;
  int unsigned   slv_delay = 0;
  logic          stray = 1'b0;
  logic [NS-1:0] req_or;

  assign req_or = bus.slv_read_request_o | bus.slv_write_request_o;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc_cnt <= 0;
    else if (|req_or) acc_cnt <= acc_cnt + 1;
    else             acc_cnt <= 0;
  end

  assign bus.slv_response_i  = ((acc_cnt >= slv_delay) ? req_or : '0)
                             | ((stray && (|req_or)) ? ~req_or : '0);
  assign bus.slv_read_data_i = {32'hD3D3_3333, 32'h1234_5678, 32'hB1B1_1111, 32'hA0A0_0000};

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned delay;
    logic        stray;
    logic [3:0]  exp_rd_req;
    logic [3:0]  exp_wr_req;
    logic [31:0] exp_saddr;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   n;
    bit   done;
    bit   req_ok;
    slv_delay           = v.delay;
    stray               = v.stray;
    bus.read_request_i  = v.rd;
    bus.write_request_i = v.wr;
    bus.address_i       = v.addr;
    bus.write_data_i    = v.wdata;
    n      = 0;
    done   = 1'b0;
    req_ok = 1'b1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.response_o) begin
        done = 1'b1;
        check($sformatf("v%0d latency", id), 32'(n), 32'(v.exp_lat));
        check($sformatf("v%0d error", id), {31'b0, bus.error_o}, {31'b0, v.exp_err});
        check($sformatf("v%0d rdata", id), bus.read_data_o, v.exp_rdata);
        if (bus.slv_read_request_o != 0 || bus.slv_write_request_o != 0) req_ok = 1'b0;
        bus.read_request_i  = 1'b0;
        bus.write_request_i = 1'b0;
      end else begin
        if (bus.slv_read_request_o !== v.exp_rd_req || bus.slv_write_request_o !== v.exp_wr_req)
          req_ok = 1'b0;
        if (n == 1) begin
          check($sformatf("v%0d slv_addr", id), bus.slv_address_o, v.exp_saddr);
          if (v.wr) check($sformatf("v%0d slv_wdata", id), bus.slv_write_data_o, v.wdata);
          // Scramble CPU fields mid-access; the latched copy must win
          bus.address_i    = 32'h8000_0300;
          bus.write_data_i = 32'hFFFF_FFFF;
        end
      end
    end
    check($sformatf("v%0d response seen", id), {31'b0, done}, 32'd1);
    check($sformatf("v%0d slave requests", id), {31'b0, req_ok}, 32'd1);
    @(negedge clk);
    check($sformatf("v%0d single pulse", id), {31'b0, bus.response_o}, 32'd0);
  endtask

  initial begin
    int hi;
    bit seen;

    // fields: rd wr addr wdata delay stray exp_rd exp_wr exp_saddr lat err rdata
    vecs[0] = '{1'b0, 1'b1, 32'h8000_0104, 32'h0000_00A5, 0, 1'b0, 4'b0000, 4'b0010, 32'h04, 2, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h8000_0200, 32'h0,         2, 1'b1, 4'b0100, 4'b0000, 32'h00, 4, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_0400, 32'h0,         0, 1'b0, 4'b0000, 4'b0000, 32'h00, 1, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         0, 1'b0, 4'b0000, 4'b0000, 32'h00, 1, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h8000_0000, 32'h1,         0, 1'b0, 4'b0000, 4'b0000, 32'h00, 1, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h8000_03FC, 32'h0,         0, 1'b0, 4'b1000, 4'b0000, 32'hFC, 2, 1'b0, 32'hD3D3_3333};
    vecs[6] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0,         1, 1'b0, 4'b0001, 4'b0000, 32'h10, 3, 1'b0, 32'hA0A0_0000};
    vecs[7] = '{1'b0, 1'b1, 32'h8000_00F0, 32'hDEAD_BEEF, 1, 1'b1, 4'b0000, 4'b0001, 32'hF0, 3, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 32'h8001_0100, 32'h0,         0, 1'b0, 4'b0000, 4'b0000, 32'h00, 1, 1'b1, 32'h0};
    vecs[9] = '{1'b1, 1'b0, 32'h8000_01FF, 32'h0,         0, 1'b0, 4'b0010, 4'b0000, 32'hFF, 2, 1'b0, 32'hB1B1_1111};

    bus.read_request_i  = 1'b0;
    bus.write_request_i = 1'b0;
    bus.address_i       = 32'h0;
    bus.write_data_i    = 32'h0;

    #12;
    check("reset response", {31'b0, bus.response_o}, 32'd0);
    check("reset error", {31'b0, bus.error_o}, 32'd0);
    check("reset rdata", bus.read_data_o, 32'h0);
    check("reset slv req", {24'b0, bus.slv_read_request_o, bus.slv_write_request_o}, 32'h0);
    check("reset slv addr", bus.slv_address_o, 32'h0);
    check("reset slv wdata", bus.slv_write_data_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Slave 3 never answers
    slv_delay          = 1000;
    stray              = 1'b0;
    bus.read_request_i = 1'b1;
    bus.address_i      = 32'h8000_0300;
    hi   = 0;
    seen = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (bus.response_o) begin
        seen = 1'b1;
        check("timeout error", {31'b0, bus.error_o}, 32'd1);
        check("timeout rdata", bus.read_data_o, 32'h0);
        bus.read_request_i = 1'b0;
      end else if (bus.slv_read_request_o[3]) begin
        hi++;
      end
    end
    check("timeout response seen", {31'b0, seen}, 32'd1);
    check("timeout request cycles", 32'(hi), 32'd16);
    @(negedge clk);
    bus.read_request_i = 1'b1;
    bus.address_i      = 32'h8000_0300;
`else
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.response_o) seen = 1'b1;
    end
    check("no timeout response", {31'b0, seen}, 32'd0);
`endif

    // Reset asserted while the slave-3 read is stalled in ACCESS
    repeat (3) @(negedge clk);
    check("stalled read request", {28'b0, bus.slv_read_request_o}, 32'b1000);
    rst_n               = 1'b0;
    bus.read_request_i  = 1'b0;
    #1;
    check("async reset slv req", {24'b0, bus.slv_read_request_o, bus.slv_write_request_o}, 32'h0);
    check("async reset response", {31'b0, bus.response_o}, 32'd0);
    repeat (2) @(negedge clk);
    check("held reset response", {31'b0, bus.response_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0], 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule

`default_nettype wire
